// File: rtl/uart_host.sv
// uart_host: serial command engine driving the CPU port of the uart peripheral.
// It receives 'W'/'R' frames, runs one 32-bit Wishbone classic cycle, and
// returns 'K', the four read bytes, or '?' for an unknown command byte.
// Optional feature macro: UART_HOST_TIMEOUT_EN (bus timeout, 'T' response).
module uart_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  CMD_RD         = 8'h52
) (
  input  logic        clk,
  input  logic        rst,
  output logic        u_rd,
  output logic        u_wr,
  output logic [1:0]  u_adr,
  output logic [7:0]  u_din,
  input  logic [7:0]  u_dout,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy
);

  localparam logic [2:0] S_POLL_RX  = 3'd0;
  localparam logic [2:0] S_RD_RX    = 3'd1;
  localparam logic [2:0] S_WB       = 3'd2;
  localparam logic [2:0] S_TX_POLL  = 3'd3;
  localparam logic [2:0] S_TX_WR    = 3'd4;
  localparam logic [2:0] S_TX_GUARD = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] txbuf_q, txbuf_d;
  logic [2:0]  txcnt_q, txcnt_d;
  logic        u_rd_q, u_rd_d;
  logic        u_wr_q, u_wr_d;
  logic [1:0]  u_adr_q, u_adr_d;
  logic [7:0]  u_din_q, u_din_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
`ifdef UART_HOST_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`endif

  // Next-state, frame assembly, tx buffer, and registered-output decode.
  always_comb begin
    state_d  = state_q;
    rx_cnt_d = rx_cnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    txbuf_d  = txbuf_q;
    txcnt_d  = txcnt_q;
    case (state_q)
      S_POLL_RX: begin
        if (u_dout[0]) state_d = S_RD_RX;
        else           state_d = S_POLL_RX;
      end
      S_RD_RX: begin
        // u_adr is 00 in this state, so u_dout carries the rx byte.
        state_d = S_POLL_RX;
        if (rx_cnt_q == 4'd0) begin
          if (u_dout == CMD_WR || u_dout == CMD_RD) begin
            is_wr_d  = (u_dout == CMD_WR);
            rx_cnt_d = 4'd1;
            addr_d   = 32'h0000_0000;
            data_d   = 32'h0000_0000;
          end else begin
            rx_cnt_d = 4'd0;
            txbuf_d  = {8'h3F, 24'h00_0000};
            txcnt_d  = 3'd1;
            state_d  = S_TX_POLL;
          end
        end else if (rx_cnt_q <= 4'd4) begin
          addr_d   = {addr_q[23:0], u_dout};
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (!is_wr_q && rx_cnt_q == 4'd4) begin
            rx_cnt_d = 4'd0;
            state_d  = S_WB;
          end
        end else begin
          data_d   = {data_q[23:0], u_dout};
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd8) begin
            rx_cnt_d = 4'd0;
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_WB;
        if (wb_ack_i) begin
          state_d = S_TX_POLL;
          if (is_wr_q) begin
            txbuf_d = {8'h4B, 24'h00_0000};
            txcnt_d = 3'd1;
          end else begin
            txbuf_d = wb_dat_i;
            txcnt_d = 3'd4;
          end
        end
`ifdef UART_HOST_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = S_TX_POLL;
          txbuf_d = {8'h54, 24'h00_0000};
          txcnt_d = 3'd1;
        end
`endif
        else begin
          state_d = S_WB;
        end
      end
      S_TX_POLL: begin
        if (!u_dout[1]) state_d = S_TX_WR;
        else            state_d = S_TX_POLL;
      end
      S_TX_WR: begin
        txcnt_d = txcnt_q - 3'd1;
        txbuf_d = {txbuf_q[23:0], 8'h00};
        state_d = S_TX_GUARD;
      end
      S_TX_GUARD: begin
        // tx_busy only rises a cycle after the write, so wait one cycle.
        if (txcnt_q != 3'd0) state_d = S_TX_POLL;
        else                 state_d = S_POLL_RX;
      end
      default: state_d = S_POLL_RX;
    endcase

    // Outputs are decoded from the next state so they are flop-driven.
    u_rd_d   = (state_d == S_RD_RX);
    u_wr_d   = (state_d == S_TX_WR);
    u_adr_d  = (state_d == S_RD_RX || state_d == S_TX_WR) ? 2'b00 : 2'b10;
    u_din_d  = (state_d == S_TX_WR) ? txbuf_q[31:24] : u_din_q;
    cyc_d    = (state_d == S_WB);
    sel_d    = (state_d == S_WB) ? 4'hF : 4'h0;
    we_d     = (state_d == S_WB) ? is_wr_d : 1'b0;
    wb_adr_d = (state_d == S_WB) ? addr_d : wb_adr_q;
    wb_dat_d = (state_d == S_WB) ? data_d : wb_dat_q;
    busy_d   = (state_d != S_POLL_RX);
`ifdef UART_HOST_TIMEOUT_EN
    tmo_d    = (state_q == S_WB && state_d == S_WB) ? tmo_q + 32'd1 : 32'd0;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_POLL_RX;
      rx_cnt_q <= 4'd0;
      is_wr_q  <= 1'b0;
      addr_q   <= 32'h0000_0000;
      data_q   <= 32'h0000_0000;
      txbuf_q  <= 32'h0000_0000;
      txcnt_q  <= 3'd0;
      u_rd_q   <= 1'b0;
      u_wr_q   <= 1'b0;
      u_adr_q  <= 2'b10;
      u_din_q  <= 8'h00;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      wb_adr_q <= 32'h0000_0000;
      wb_dat_q <= 32'h0000_0000;
      sel_q    <= 4'h0;
      busy_q   <= 1'b0;
`ifdef UART_HOST_TIMEOUT_EN
      tmo_q    <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      rx_cnt_q <= rx_cnt_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      txbuf_q  <= txbuf_d;
      txcnt_q  <= txcnt_d;
      u_rd_q   <= u_rd_d;
      u_wr_q   <= u_wr_d;
      u_adr_q  <= u_adr_d;
      u_din_q  <= u_din_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
`ifdef UART_HOST_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign u_rd     = u_rd_q;
  assign u_wr     = u_wr_q;
  assign u_adr    = u_adr_q;
  assign u_din    = u_din_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = wb_adr_q;
  assign wb_dat_o = wb_dat_q;
  assign wb_sel_o = sel_q;
  assign busy     = busy_q;

endmodule

// File: doc/uart_host.md
Name: uart_host

Overview:
- Bus-master command engine that drives the CPU-side register port of the existing `uart` peripheral.
- Polls the UART status, reads received bytes and assembles simple serial commands.
- Executes each command as a 32-bit Wishbone classic single-cycle read or write, then writes a response back through the UART.
- Lets an external host load and inspect memory over the serial link with no J1 core involved.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles to wait for `wb_ack_i` (used only with the optional feature).
- CMD_WR, 8'h57: command byte for a write ('W').
- CMD_RD, 8'h52: command byte for a read ('R').

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- u_rd  out  1  UART read strobe (consumes the rx byte)
- u_wr  out  1  UART write strobe (starts a tx byte)
- u_adr  out  2  UART register address; 2'b10 = status, 2'b00 = data
- u_din  out  8  tx byte to the UART
- u_dout  in  8  UART read data; combinational from `u_adr`; status bit0 = rx_ok, bit1 = tx_busy
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  32  Wishbone byte address
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte selects; always 4'hF during a cycle
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- busy  out  1  high in any state other than S_POLL_RX

Behaviour:
- Single clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: `u_rd`=0, `u_wr`=0, `u_adr`=2'b10, `u_din`=0, `wb_cyc_o`=0, `wb_stb_o`=0, `wb_we_o`=0, `wb_adr_o`=0, `wb_dat_o`=0, `wb_sel_o`=0, `busy`=0, state=S_POLL_RX, byte count=0.
- Reset mid-operation (including mid-Wishbone-cycle) returns to reset state in one cycle. Any partial command is discarded. `cyc`/`stb` drop immediately.

Command framing:
- Write: CMD_WR, A3, A2, A1, A0, D3, D2, D1, D0 (MSB first).
- Read: CMD_RD, A3, A2, A1, A0.
- Responses:
  - Write done: 8'h4B ('K').
  - Read: D3, D2, D1, D0 from `wb_dat_i` (MSB first).
  - Unknown first byte: 8'h3F ('?'); the byte is dropped and the count resets to 0.

States and transitions:
- S_POLL_RX: `u_adr`=10, `u_rd`=0. If `u_dout[0]` → S_RD_RX.
- S_RD_RX: `u_adr`=00, `u_rd`=1 for exactly 1 cycle. Capture `u_dout` this same cycle (data valid while rx_ok is still 1).
  - Byte 0: checked against CMD_WR / CMD_RD, otherwise the '?' response.
  - Subsequent bytes shift into the addr/data registers.
  - When the frame is complete → S_WB; otherwise → S_POLL_RX.
  - rx_ok clears at the same edge, so the next S_POLL_RX sees 0. There is no double read.
- S_WB: assert `cyc`/`stb` with `sel`=F, `we` per command, `adr`/`dat` from the assembled registers. Hold until `wb_ack_i`.
  - On the ack cycle: deassert `cyc`/`stb` at the next edge, latch `wb_dat_i` for reads, load the tx shift buffer and count (1 for 'K'/'?', 4 for read) → S_TX_POLL.
  - An ack in the first cycle of `stb` is legal: minimum 1-cycle bus transaction.
- S_TX_POLL: `u_adr`=10. If `u_dout[1]`==0 → S_TX_WR.
- S_TX_WR: `u_adr`=00, `u_din`=buffer MSB byte, `u_wr`=1 for exactly 1 cycle; decrement the count → S_TX_GUARD.
- S_TX_GUARD: 1 idle cycle, `u_adr`=10, since tx_busy rises only one cycle after the write. Then → S_TX_POLL if count≠0, else S_POLL_RX.

Rules:
- `u_rd` and `u_wr` are never high together.
- Bytes arriving while the block is not in S_POLL_RX stay in the UART; the UART holds one byte, and a later byte overwrites it. A host must wait for the response before sending the next frame.
- Address and data registers are fully rewritten each frame; there is no carry between frames.

Optional Feature:
- Macro: UART_HOST_TIMEOUT_EN.
- Defined: a counter starts at 0 on entry to S_WB. If it reaches TIMEOUT_CYCLES with no ack, `cyc`/`stb` drop at the next edge and the response is the single byte 8'h54 ('T') for both reads and writes. The counter resets on every S_WB entry.
- Undefined: no counter logic is present and S_WB waits indefinitely for `wb_ack_i`.

Test Plan:
- Write frame: rx 57 00 00 10 00 DE AD BE EF, slave acks after 3 cycles → one WB write, adr=32'h00001000, dat=32'hDEADBEEF, sel=F, we=1; tx sends 4B.
- Read frame: rx 52 00 00 10 04 → WB read at 32'h00001004; slave returns 32'h12345678 with same-cycle ack → tx sends 12, 34, 56, 78 in order. Each `u_wr` is issued only after status bit1 reads 0, and each is followed by a guard cycle.
- Unknown command: rx 41 → tx 3F, no WB activity. A following 52 00 00 00 00 frame is then accepted normally.
- Reset mid-frame: rx 57 00 00, assert `rst` for 1 cycle, then a full read frame → only the read executes. All outputs were at reset values during and after the `rst` cycle.
- Reset during S_WB: `rst` asserted while `stb`=1 → `cyc`/`stb`=0 on the next cycle and no tx byte is sent.
- UART_HOST_TIMEOUT_EN with TIMEOUT_CYCLES=16: read frame, slave never acks → `stb` drops after 16 cycles and tx sends 54. Without the macro, `stb` stays high for 1000+ cycles.
